// File: rtl/regression_sample_loader.sv
// regression_sample_loader
//
// Takes a stream of signed fixed-point (x, y) sample pairs over a valid/ready
// handshake and stores up to DEPTH pairs. While it loads, it also builds the
// regression sums sum_x, sum_y, sum_xx and sum_xy. The stored samples can then
// be replayed in load order as many times as needed.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 begin a new load (IDLE/HOLD only)
//   in_valid, in_last     input strobe and end-of-load marker
//   x_bus, y_bus          input sample (W bits, FRAC_BITS fractional)
//   in_ready              a sample is accepted this cycle if in_valid is high
//   sums_valid            sums and n_samples are final
//   n_samples             number of samples stored by the current load
//   sum_x, sum_y          signed sums (SW bits)
//   sum_xx, sum_xy        signed sums of full products (PW bits)
//   replay_start          begin replay (HOLD only)
//   x, y                  replayed sample
//   out_valid, out_last   replay strobe and final-sample marker
//   done                  one-cycle pulse after a replay completes
module regression_sample_loader #(
  parameter int INT_BITS  = 10,
  parameter int FRAC_BITS = 10,
  parameter int DEPTH     = 256,
  localparam int W  = INT_BITS + FRAC_BITS,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int SW = W + CW,
  localparam int PW = 2 * W + CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [W-1:0]  x_bus,
  input  logic [W-1:0]  y_bus,
  output logic          in_ready,
  output logic          sums_valid,
  output logic [CW-1:0] n_samples,
  output logic [SW-1:0] sum_x,
  output logic [SW-1:0] sum_y,
  output logic [PW-1:0] sum_xx,
  output logic [PW-1:0] sum_xy,
  input  logic          replay_start,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  output logic          out_valid,
  output logic          out_last,
  output logic          done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, REPLAY} state_t;

  state_t state;

  logic [W-1:0]  x_mem [0:DEPTH-1];
  logic [W-1:0]  y_mem [0:DEPTH-1];

  // The read address and the remaining-sample count are kept apart. The
  // address then only needs AW bits, and the count alone decides when the
  // replay ends.
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_left;

  logic signed [2*W-1:0] prod_xx;
  logic signed [2*W-1:0] prod_xy;
  logic                  accept;

  assign accept  = (state == LOAD) && in_valid && in_ready;
  assign prod_xx = $signed(x_bus) * $signed(x_bus);
  assign prod_xy = $signed(x_bus) * $signed(y_bus);

  // Sample buffer. It has no reset, and its contents only matter once a load
  // has written them.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_mem[n_samples[AW-1:0]] <= x_bus;
      y_mem[n_samples[AW-1:0]] <= y_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      sums_valid <= 1'b0;
      n_samples  <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      sum_xx     <= '0;
      sum_xy     <= '0;
      x          <= '0;
      y          <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      rd_addr    <= '0;
      rd_left    <= '0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          // start takes priority over replay_start when both arrive in HOLD
          if (start) begin
            state      <= LOAD;
            in_ready   <= 1'b1;
            sums_valid <= 1'b0;
            n_samples  <= '0;
            sum_x      <= '0;
            sum_y      <= '0;
            sum_xx     <= '0;
            sum_xy     <= '0;
          end else if (state == HOLD && replay_start) begin
            state   <= REPLAY;
            rd_addr <= '0;
            rd_left <= n_samples;
          end
        end

        LOAD: begin
          if (accept) begin
            n_samples <= n_samples + CW'(1);
            sum_x     <= sum_x + {{CW{x_bus[W-1]}}, x_bus};
            sum_y     <= sum_y + {{CW{y_bus[W-1]}}, y_bus};
            sum_xx    <= sum_xx + {{CW{prod_xx[2*W-1]}}, prod_xx};
            sum_xy    <= sum_xy + {{CW{prod_xy[2*W-1]}}, prod_xy};
            if (in_last || n_samples == CW'(DEPTH - 1)) begin
              state      <= HOLD;
              in_ready   <= 1'b0;
              sums_valid <= 1'b1;
            end
          end
        end

        REPLAY: begin
          // Three phases: issue reads while samples remain, then one cycle
          // for the done pulse, then go back to HOLD. Because the output is
          // registered, each sample appears one cycle after its read.
          if (rd_left != '0) begin
            x         <= x_mem[rd_addr];
            y         <= y_mem[rd_addr];
            out_valid <= 1'b1;
            out_last  <= (rd_left == CW'(1));
            rd_left   <= rd_left - CW'(1);
            rd_addr   <= rd_addr + AW'(1);
          end else if (out_valid) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= HOLD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regression_sample_loader.sv
// Directed testbench for regression_sample_loader. It drives two instances
// from the same inputs: the default DEPTH=256 unit and a DEPTH=4 unit that is
// used to exercise the full-buffer case.
module tb_regression_sample_loader;

  localparam int W   = 20;
  localparam int CW  = 9;
  localparam int SW  = 29;
  localparam int PW  = 49;
  localparam int CW4 = 3;
  localparam int SW4 = 23;
  localparam int PW4 = 43;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          replay_start = 1'b0;
  logic [W-1:0]  x_bus = '0;
  logic [W-1:0]  y_bus = '0;

  logic          in_ready, sums_valid, out_valid, out_last, done;
  logic [CW-1:0] n_samples;
  logic [SW-1:0] sum_x, sum_y;
  logic [PW-1:0] sum_xx, sum_xy;
  logic [W-1:0]  x, y;

  logic           in_ready4, sums_valid4, out_valid4, out_last4, done4;
  logic [CW4-1:0] n_samples4;
  logic [SW4-1:0] sum_x4, sum_y4;
  logic [PW4-1:0] sum_xx4, sum_xy4;
  logic [W-1:0]   x4, y4;

  int vectors = 0;
  int miscompares = 0;

  regression_sample_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_last(in_last), .x_bus(x_bus), .y_bus(y_bus), .in_ready(in_ready),
    .sums_valid(sums_valid), .n_samples(n_samples), .sum_x(sum_x),
    .sum_y(sum_y), .sum_xx(sum_xx), .sum_xy(sum_xy),
    .replay_start(replay_start), .x(x), .y(y), .out_valid(out_valid),
    .out_last(out_last), .done(done)
  );

  regression_sample_loader #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_last(in_last), .x_bus(x_bus), .y_bus(y_bus), .in_ready(in_ready4),
    .sums_valid(sums_valid4), .n_samples(n_samples4), .sum_x(sum_x4),
    .sum_y(sum_y4), .sum_xx(sum_xx4), .sum_xy(sum_xy4),
    .replay_start(replay_start), .x(x4), .y(y4), .out_valid(out_valid4),
    .out_last(out_last4), .done(done4)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_sample(input logic [W-1:0] xv, input logic [W-1:0] yv,
                             input logic last);
    in_valid = 1'b1; x_bus = xv; y_bus = yv; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || sums_valid !== 1'b0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got rdy=%b sv=%b ov=%b ol=%b dn=%b expected all 0",
               in_ready, sums_valid, out_valid, out_last, done);
    end
    vectors++;
    if (n_samples !== '0 || sum_x !== '0 || sum_y !== '0 || sum_xx !== '0 ||
        sum_xy !== '0 || x !== '0 || y !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got n=%0d sx=%0d sy=%0d sxx=%0d sxy=%0d x=%0d y=%0d expected all 0",
               n_samples, sum_x, sum_y, sum_xx, sum_xy, x, y);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    load_sample(20'h00400, 20'h00400, 1'b0);
    load_sample(20'h00800, 20'h00400, 1'b0);
    load_sample(20'h00C00, 20'h00400, 1'b0);
    vectors++;
    if (n_samples !== CW'(3)) begin
      miscompares++;
      $display("[TB] FAIL midload_count: got %0d expected 3", n_samples);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || n_samples !== '0 || sum_x !== '0 || sums_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midload_reset: got rdy=%b n=%0d sx=%0d sv=%b expected 0 0 0 0",
               in_ready, n_samples, sum_x, sums_valid);
    end
    pulse_start();
    vectors++;
    if (in_ready !== 1'b1 || n_samples !== '0) begin
      miscompares++;
      $display("[TB] FAIL restart: got rdy=%b n=%0d expected rdy=1 n=0", in_ready, n_samples);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic_load();
    pulse_start();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL load_ready: got %b expected 1", in_ready);
    end
    load_sample(20'h00600, 20'h00800, 1'b0);
    vectors++;
    if (n_samples !== CW'(1) || sums_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_first: got n=%0d sv=%b expected n=1 sv=0", n_samples, sums_valid);
    end
    load_sample(20'hFFC00, 20'h00200, 1'b1);
    vectors++;
    if (n_samples !== CW'(2)) begin
      miscompares++;
      $display("[TB] FAIL basic_n: got %0d expected 2", n_samples);
    end
    vectors++;
    if (sum_x !== SW'(512) || sum_y !== SW'(2560)) begin
      miscompares++;
      $display("[TB] FAIL basic_sum_xy1: got sx=%0d sy=%0d expected 512 2560", sum_x, sum_y);
    end
    vectors++;
    if (sum_xx !== PW'(3407872)) begin
      miscompares++;
      $display("[TB] FAIL basic_sum_xx: got %0d expected 3407872", sum_xx);
    end
    vectors++;
    if (sum_xy !== PW'(2621440)) begin
      miscompares++;
      $display("[TB] FAIL basic_sum_xy: got %0d expected 2621440", sum_xy);
    end
    vectors++;
    if (sums_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_hold: got sv=%b rdy=%b expected sv=1 rdy=0", sums_valid, in_ready);
    end
  endtask

  task automatic test_replay();
    for (int r = 0; r < 2; r++) begin
      replay_start = 1'b1;
      tick();
      replay_start = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL replay_latency: got ov=%b expected 0", out_valid);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_last !== 1'b0 || x !== 20'h00600 || y !== 20'h00800) begin
        miscompares++;
        $display("[TB] FAIL replay_s0: got ov=%b ol=%b x=%h y=%h expected 1 0 00600 00800",
                 out_valid, out_last, x, y);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_last !== 1'b1 || x !== 20'hFFC00 || y !== 20'h00200) begin
        miscompares++;
        $display("[TB] FAIL replay_s1: got ov=%b ol=%b x=%h y=%h expected 1 1 ffc00 00200",
                 out_valid, out_last, x, y);
      end
      tick();
      vectors++;
      if (done !== 1'b1 || out_valid !== 1'b0 || x !== 20'hFFC00) begin
        miscompares++;
        $display("[TB] FAIL replay_done: got dn=%b ov=%b x=%h expected 1 0 ffc00", done, out_valid, x);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || sums_valid !== 1'b1 || sum_xy !== PW'(2621440) || n_samples !== CW'(2)) begin
        miscompares++;
        $display("[TB] FAIL replay_after: got dn=%b sv=%b sxy=%0d n=%0d expected 0 1 2621440 2",
                 done, sums_valid, sum_xy, n_samples);
      end
    end
  endtask

  task automatic test_priority();
    start = 1'b1; replay_start = 1'b1;
    tick();
    start = 1'b0; replay_start = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || sums_valid !== 1'b0 || n_samples !== '0 || sum_x !== '0 || sum_xx !== '0) begin
      miscompares++;
      $display("[TB] FAIL prio_start: got rdy=%b sv=%b n=%0d sx=%0d sxx=%0d expected 1 0 0 0 0",
               in_ready, sums_valid, n_samples, sum_x, sum_xx);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL prio_no_replay: got ov=%b expected 0", out_valid);
    end
    load_sample(20'h00400, 20'h00400, 1'b1);
    vectors++;
    if (n_samples !== CW'(1) || sum_xy !== PW'(1048576)) begin
      miscompares++;
      $display("[TB] FAIL prio_load: got n=%0d sxy=%0d expected 1 1048576", n_samples, sum_xy);
    end
    replay_start = 1'b1;
    tick();
    replay_start = 1'b0;
    start = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || x !== 20'h00400) begin
      miscompares++;
      $display("[TB] FAIL ignore_start_s0: got ov=%b ol=%b x=%h expected 1 1 00400", out_valid, out_last, x);
    end
    tick();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ignore_start_done: got %b expected 1", done);
    end
    start = 1'b0;
    tick();
    vectors++;
    if (sums_valid !== 1'b1 || in_ready !== 1'b0 || n_samples !== CW'(1) || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_start_hold: got sv=%b rdy=%b n=%0d dn=%b expected 1 0 1 0",
               sums_valid, in_ready, n_samples, done);
    end
  endtask

  task automatic test_full_buffer();
    int accepted = 0;
    pulse_start();
    for (int k = 1; k <= 6; k++) begin
      if (in_ready4) accepted++;
      load_sample(W'(k * 1024), 20'h00400, 1'b0);
      if (k == 4) begin
        vectors++;
        if (in_ready4 !== 1'b0 || sums_valid4 !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL full_ready_drop: got rdy=%b sv=%b expected 0 1", in_ready4, sums_valid4);
        end
      end
    end
    vectors++;
    if (accepted != 4 || n_samples4 !== CW4'(4)) begin
      miscompares++;
      $display("[TB] FAIL full_count: got acc=%0d n=%0d expected 4 4", accepted, n_samples4);
    end
    vectors++;
    if (sum_x4 !== SW4'(10240) || sum_xx4 !== PW4'(31457280)) begin
      miscompares++;
      $display("[TB] FAIL full_sums: got sx=%0d sxx=%0d expected 10240 31457280", sum_x4, sum_xx4);
    end
    // the DEPTH=256 unit is still loading; close its load
    load_sample(20'h00000, 20'h00000, 1'b1);
    vectors++;
    if (n_samples !== CW'(7) || sums_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL deep_count: got n=%0d sv=%b expected 7 1", n_samples, sums_valid);
    end
  endtask

  task automatic test_gapped();
    logic [W-1:0] xs [5];
    logic [W-1:0] ys [5];
    longint ex_x = 0, ex_y = 0, ex_xx = 0, ex_xy = 0;
    xs = '{20'h00400, 20'hFFE00, 20'h7FFFF, 20'h80000, 20'h00001};
    ys = '{20'h00C00, 20'h00100, 20'h80000, 20'h7FFFF, 20'hFFFFF};
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      longint xv, yv;
      xv = longint'($signed(xs[i]));
      yv = longint'($signed(ys[i]));
      ex_x += xv; ex_y += yv; ex_xx += xv * xv; ex_xy += xv * yv;
      load_sample(xs[i], ys[i], i == 4);
      if (i < 4) begin
        // idle cycle with a stray in_last that must be ignored
        x_bus = 20'h12345; in_last = 1'b1;
        tick();
        in_last = 1'b0;
      end
    end
    vectors++;
    if (n_samples !== CW'(5) || sums_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gap_count: got n=%0d sv=%b expected 5 1", n_samples, sums_valid);
    end
    vectors++;
    if (sum_x !== SW'(ex_x) || sum_y !== SW'(ex_y)) begin
      miscompares++;
      $display("[TB] FAIL gap_sum_xy1: got sx=%0d sy=%0d expected %0d %0d", sum_x, sum_y, SW'(ex_x), SW'(ex_y));
    end
    vectors++;
    if (sum_xx !== PW'(ex_xx) || sum_xy !== PW'(ex_xy)) begin
      miscompares++;
      $display("[TB] FAIL gap_sum_prod: got sxx=%0d sxy=%0d expected %0d %0d",
               sum_xx, sum_xy, PW'(ex_xx), PW'(ex_xy));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_basic_load();
    test_replay();
    test_priority();
    test_full_buffer();
    test_gapped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
